// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and constants for the
// unified-memory port arbiter of the riscv core.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_D
    } resp_owner_e;

    localparam int MEM_ADDR_W = 9;
    localparam int BE_W = 4;
    localparam logic [BE_W-1:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/arb_fair_cnt.sv
// arb_fair_cnt: saturating starvation counter; at_max
// tells the arbiter fetch has waited long enough.
module arb_fair_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt;

    assign at_max = (cnt == MAX);

    // clear wins over increment; counter sticks at MAX
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency RAM between
// fetch and load/store, data first with fetch fairness.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    resp_owner_e resp_owner;
    resp_owner_e resp_next;
    logic        at_max;
    logic        if_win;

    arb_fair_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_fair (
        .clk   (clk),
        .reset (reset),
        .inc   (d_gnt && if_req),
        .clr   (if_gnt || !if_req),
        .at_max(at_max)
    );

    // data wins unless fetch has been starved long enough
    always_comb begin
        if_win = if_req && (!d_req || at_max);
        if_gnt = reset && if_win;
        d_gnt  = reset && d_req && !if_win;
    end

    // drive the RAM from the winner; idle cycles are all zero
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        resp_next = RESP_NONE;
        unique case (1'b1)
            d_gnt: begin
                mem_en   = 1'b1;
                mem_we   = d_we;
                mem_addr = d_addr;
                if (d_we) begin
                    mem_be    = d_be;
                    mem_wdata = d_wdata;
                end else begin
                    mem_be    = BE_ALL;
                    resp_next = RESP_D;
                end
            end
            if_gnt: begin
                mem_en    = 1'b1;
                mem_be    = BE_ALL;
                mem_addr  = if_addr;
                resp_next = RESP_IF;
            end
            default: begin
            end
        endcase
    end

    // remember who owns the read data arriving next cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_owner <= RESP_NONE;
        end else begin
            resp_owner <= resp_next;
        end
    end

    // route read data; quiet ports see zero
    always_comb begin
        if_rvalid = reset && (resp_owner == RESP_IF);
        d_rvalid  = reset && (resp_owner == RESP_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration,
// fairness, RAM drive and read-data routing.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:511];

    int passed;
    int total;

    mem_port_arbiter #(
        .ADDR_W(9),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port RAM, one cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        if_req = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        if_addr = 9'd11;
        d_addr = 9'd10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata,
                 if_rvalid, d_rvalid, if_rdata, d_rdata} !== '0)
                $display("FAIL reset_outputs: got gnt=%b%b en=%b addr=%h rv=%b%b want all 0",
                         if_gnt, d_gnt, mem_en, mem_addr, if_rvalid, d_rvalid);
            else passed++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({if_gnt, d_gnt, mem_addr} !== {1'b0, 1'b1, 9'd10})
            $display("FAIL reset_release: got if_gnt=%b d_gnt=%b addr=%h want 0 1 00a",
                     if_gnt, d_gnt, mem_addr);
        else passed++;
        @(negedge clk);
        d_req = 1'b0;
        #1;
        total++;
        if ({if_gnt, mem_addr, d_rvalid, d_rdata} !== {1'b1, 9'd11, 1'b1, 32'h0A0A_0A0A})
            $display("FAIL reset_first_resp: got if_gnt=%b addr=%h d_rv=%b d_rdata=%h want 1 00b 1 0a0a0a0a",
                     if_gnt, mem_addr, d_rvalid, d_rdata);
        else passed++;
        @(negedge clk);
        if_req = 1'b0;
        #1;
        total++;
        if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'h0B0B_0B0B, 1'b0})
            $display("FAIL reset_if_resp: got if_rv=%b if_rdata=%h d_rv=%b want 1 0b0b0b0b 0",
                     if_rvalid, if_rdata, d_rvalid);
        else passed++;
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 9'd5;
        #1;
        total++;
        if ({if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 9'd5})
            $display("FAIL fetch_grant: got gnt=%b%b en=%b we=%b be=%h addr=%h want 10 1 0 f 005",
                     if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr);
        else passed++;
        @(negedge clk);
        if_req = 1'b0;
        #1;
        total++;
        if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0})
            $display("FAIL fetch_resp: got if_rv=%b if_rdata=%h d_rv=%b d_rdata=%h want 1 deadbeef 0 0",
                     if_rvalid, if_rdata, d_rvalid, d_rdata);
        else passed++;
    endtask

    task automatic test_write_readback();
        @(negedge clk);
        d_req = 1'b1;
        d_we = 1'b1;
        d_be = 4'b0011;
        d_addr = 9'd7;
        d_wdata = 32'h1234_ABCD;
        #1;
        total++;
        if ({d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 1'b1, 4'b0011, 9'd7, 32'h1234_ABCD})
            $display("FAIL write_drive: got gnt=%b en=%b we=%b be=%h addr=%h wdata=%h want 1 1 1 3 007 1234abcd",
                     d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        else passed++;
        @(negedge clk);
        d_req = 1'b0;
        d_we = 1'b0;
        #1;
        total++;
        if ({if_rvalid, d_rvalid} !== 2'b00)
            $display("FAIL write_no_resp: got rv=%b%b want 00", if_rvalid, d_rvalid);
        else passed++;
        @(negedge clk);
        d_req = 1'b1;
        d_we = 1'b1;
        d_be = 4'b0000;
        d_wdata = 32'hFFFF_FFFF;
        #1;
        total++;
        if ({d_gnt, mem_en, mem_we, mem_be} !== {1'b1, 1'b1, 1'b1, 4'b0000})
            $display("FAIL zero_be_write: got gnt=%b en=%b we=%b be=%h want 1 1 1 0",
                     d_gnt, mem_en, mem_we, mem_be);
        else passed++;
        @(negedge clk);
        d_we = 1'b0;
        #1;
        total++;
        if ({d_gnt, mem_we, mem_be, mem_wdata, d_rvalid} !=
            {1'b1, 1'b0, 4'hF, 32'h0, 1'b0})
            $display("FAIL read_drive: got gnt=%b we=%b be=%h wdata=%h d_rv=%b want 1 0 f 0 0",
                     d_gnt, mem_we, mem_be, mem_wdata, d_rvalid);
        else passed++;
        @(negedge clk);
        d_req = 1'b0;
        #1;
        total++;
        if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, 32'h0000_ABCD, 1'b0})
            $display("FAIL write_readback: got d_rv=%b d_rdata=%h if_rv=%b want 1 0000abcd 0",
                     d_rvalid, d_rdata, if_rvalid);
        else passed++;
    endtask

    task automatic test_fairness();
        logic exp_if;
        logic prev_if;
        prev_if = 1'b0;
        @(negedge clk);
        if_req = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        if_addr = 9'd20;
        d_addr = 9'd21;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_if = (i == 4) || (i == 9);
            total++;
            if ({if_gnt, d_gnt} !== {exp_if, ~exp_if})
                $display("FAIL fair_grant_%0d: got if_gnt=%b d_gnt=%b want %b %b",
                         i, if_gnt, d_gnt, exp_if, ~exp_if);
            else passed++;
            if (i > 0) begin
                total++;
                if ({if_rvalid, d_rvalid} !== {prev_if, ~prev_if})
                    $display("FAIL fair_route_%0d: got rv=%b%b want %b%b",
                             i, if_rvalid, d_rvalid, prev_if, ~prev_if);
                else passed++;
            end
            prev_if = exp_if;
            @(negedge clk);
        end
        if_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 9'd1;
        #1;
        total++;
        if (if_gnt !== 1'b1)
            $display("FAIL b2b_gnt_n: got if_gnt=%b want 1", if_gnt);
        else passed++;
        @(negedge clk);
        if_req = 1'b0;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 9'd2;
        #1;
        total++;
        if ({d_gnt, if_rvalid, if_rdata, d_rvalid} !== {1'b1, 1'b1, 32'h1111_1111, 1'b0})
            $display("FAIL b2b_n1: got d_gnt=%b if_rv=%b if_rdata=%h d_rv=%b want 1 1 11111111 0",
                     d_gnt, if_rvalid, if_rdata, d_rvalid);
        else passed++;
        @(negedge clk);
        d_req = 1'b0;
        if_req = 1'b1;
        if_addr = 9'd3;
        #1;
        total++;
        if ({if_gnt, d_rvalid, d_rdata, if_rvalid, if_rdata} !==
            {1'b1, 1'b1, 32'h2222_2222, 1'b0, 32'h0})
            $display("FAIL b2b_n2: got if_gnt=%b d_rv=%b d_rdata=%h if_rv=%b if_rdata=%h want 1 1 22222222 0 0",
                     if_gnt, d_rvalid, d_rdata, if_rvalid, if_rdata);
        else passed++;
        @(negedge clk);
        if_req = 1'b0;
        #1;
        total++;
        if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'h3333_3333, 1'b0})
            $display("FAIL b2b_n3: got if_rv=%b if_rdata=%h d_rv=%b want 1 33333333 0",
                     if_rvalid, if_rdata, d_rvalid);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 9'd2;
        #1;
        total++;
        if (d_gnt !== 1'b1)
            $display("FAIL mid_gnt: got d_gnt=%b want 1", d_gnt);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({d_rvalid, d_rdata, if_rvalid} !== {1'b0, 32'h0, 1'b0})
                $display("FAIL mid_resp_%0d: got d_rv=%b d_rdata=%h if_rv=%b want 0 0 0",
                         i, d_rvalid, d_rdata, if_rvalid);
            else passed++;
            @(negedge clk);
            if (i == 1) reset = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        passed = 0;
        total = 0;
        for (int a = 0; a < 512; a++) ram[a] = '0;
        ram[1] = 32'h1111_1111;
        ram[2] = 32'h2222_2222;
        ram[3] = 32'h3333_3333;
        ram[5] = 32'hDEAD_BEEF;
        ram[10] = 32'h0A0A_0A0A;
        ram[11] = 32'h0B0B_0B0B;
        mem_rdata = '0;
        reset = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_be = '0;
        d_addr = '0;
        d_wdata = '0;
        test_reset();
        test_fetch_read();
        test_write_readback();
        test_fairness();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous RAM (1-cycle read latency) between the core's instruction-fetch port and its load/store port, for the unified-memory build of the `riscv` core. One access is granted per cycle. Data accesses win by default, but a fairness counter guarantees fetch forward progress. Read data is routed back to whichever port owns the outstanding read.

## Interface
- `ADDR_W`, 9: word-address width of both ports and the RAM.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: consecutive data grants allowed while fetch is waiting, before fetch is forced to win.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch read data valid.
- `if_rdata`  out  DATA_W  fetch read data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = write, 0 = read.
- `d_be`  in  4  byte enables (writes only).
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  DATA_W  write data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data read data valid.
- `d_rdata`  out  DATA_W  data read data.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write.
- `mem_be`  out  4  RAM byte enables.
- `mem_addr`  out  ADDR_W  RAM word address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after a read strobe.

## Operation
Request handshake:
- A requester raises `req` with stable address/data and holds them unchanged until the cycle `gnt` = 1. A request is consumed in its `gnt` cycle.
- Grants are combinational from the same-cycle requests. At most one of `if_gnt` / `d_gnt` is high per cycle.

Arbitration:
- Only `d_req` high → data granted.
- Only `if_req` high → fetch granted.
- Both high → data granted unless `starve_cnt == STARVE_MAX`, in which case fetch is granted.
- `starve_cnt` increments on each data grant while `if_req` is high, saturating at `STARVE_MAX`. It clears on any fetch grant, and on any cycle where `if_req` is low.

RAM drive:
- In the grant cycle, `mem_en` = 1 and `mem_addr` = the winner's address.
- For a data write: `mem_we` = 1 and `mem_be`/`mem_wdata` follow the port.
- For any read: `mem_we` = 0 and `mem_be` = 4'b1111.
- With no grant, all `mem_*` outputs are 0.
- A write with `d_be` = 0 is still granted and strobed (`mem_we` = 1, `mem_be` = 0). It produces no response.

Response routing:
- Register `resp_owner` ∈ {NONE, IF, D} is set at every edge to the owner of the read granted that cycle (NONE for a write or an idle cycle).
- Next cycle: `resp_owner` = IF → `if_rvalid` = 1 and `if_rdata` = `mem_rdata`; `resp_owner` = D → `d_rvalid` = 1 and `d_rdata` = `mem_rdata`.
- When a port's `rvalid` = 0, its `rdata` = 0.
- Writes never produce `rvalid`.

## Timing
- Grant: 0 cycles after request (same cycle).
- Read data: exactly 1 cycle after the grant cycle.
- Back-to-back grants are allowed every cycle. A response and a new grant may occur in the same cycle, including to the same port.
- Reset (`reset` = 0 at an edge):
  - `resp_owner` ← NONE and `starve_cnt` ← 0.
  - While `reset` is low, all grants, `rvalid`s, `rdata`s and `mem_*` outputs are forced to 0.
  - A read granted in the cycle before reset asserts never returns `rvalid`.
- First grant is possible in the first cycle with `reset` = 1.
- Simultaneous request and fairness boundary: when `starve_cnt == STARVE_MAX` and both ports request, fetch wins. Data's request is held and wins the following cycle, because the counter has cleared.
- `STARVE_MAX` = 0 gives fetch strict priority when both request.

## Structure
- Package `riscv_mem_pkg` holds:
  - `resp_owner_e` enum {RESP_NONE, RESP_IF, RESP_D};
  - `MEM_ADDR_W` = 9;
  - `BE_W` = 4;
  - `BE_ALL` = 4'b1111.
- One sub-module, `arb_fair_cnt`: saturating counter with inputs `inc`, `clr`, and output `at_max`, parameterised by `STARVE_MAX`.
- Everything else lives in `mem_port_arbiter`.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with both `req` high → all outputs 0. Release → first cycle `d_gnt` = 1, `if_gnt` = 0.
- **Fetch read:** RAM[5] = 32'hDEADBEEF; `if_req` with `if_addr` = 5 → `if_gnt` same cycle, `mem_addr` = 5, `mem_we` = 0; next cycle `if_rvalid` = 1 and `if_rdata` = 32'hDEADBEEF, `d_rvalid` = 0.
- **Write then read back:** `d_req`, `d_we` = 1, `d_be` = 4'b0011, `d_addr` = 7, `d_wdata` = 32'h1234_ABCD over RAM[7] = 0 → no `rvalid`. Then read addr 7 → `d_rdata` = 32'h0000_ABCD.
- **Fairness:** both `req` held high continuously, `STARVE_MAX` = 4 → grant pattern D, D, D, D, IF, D, D, D, D, IF…
- **Back-to-back routing:** fetch read addr 1 (cycle n), data read addr 2 (n+1), fetch read addr 3 (n+2) → `rvalid`s at n+1 (IF), n+2 (D), n+3 (IF) with matching data. Never both `rvalid`s high.
- **Reset mid-read:** data read granted at cycle n, `reset` = 0 at edge n+1 → `d_rvalid` stays 0 through reset and after release.
